data_bus_arbiter: RTL and testbench

- Shares the single core data bus (RAM, ROM data port, PIO) between two masters: M0, the RV32I core data port, and M1, a DMA/debug master.
- Grants one master per cycle and drives the shared slave-side address, write data and write strobes.
- Routes synchronous read data back to the master that issued the read.
- Generates the core stall line, so the core freezes while M1 owns the bus.

---
 rtl/data_bus_arbiter_if.sv | 60 ++++++
 rtl/data_bus_arbiter.sv | 117 +++++++++++
 tb/tb_data_bus_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_arbiter_if.sv
// Bundle of the two master ports and the shared slave port of data_bus_arbiter.
// The m1_lock signal exists only when DATA_BUS_ARBITER_LOCK_EN is defined.
interface data_bus_arbiter_if #(
  parameter int unsigned ADDR_BUS_WIDTH = 16
);
  logic                      m0_req;
  logic [ADDR_BUS_WIDTH-1:0] m0_addr;
  logic [31:0]               m0_wdata;
  logic                      m0_wr_w;
  logic                      m0_wr_h;
  logic                      m0_wr_b;
  logic                      m0_stall;
  logic [31:0]               m0_rdata;

  logic                      m1_req;
  logic [ADDR_BUS_WIDTH-1:0] m1_addr;
  logic [31:0]               m1_wdata;
  logic                      m1_wr_w;
  logic                      m1_wr_h;
  logic                      m1_wr_b;
  logic                      m1_gnt;
  logic [31:0]               m1_rdata;
  logic                      m1_rvalid;
`ifdef DATA_BUS_ARBITER_LOCK_EN
  logic                      m1_lock;
`endif

  logic [ADDR_BUS_WIDTH-1:0] s_addr;
  logic [31:0]               s_wdata;
  logic                      s_wr_w;
  logic                      s_wr_h;
  logic                      s_wr_b;
  logic [31:0]               s_rdata;

  // Arbiter view: it is the slave of both masters and fronts the shared slave.
  modport slave (
`ifdef DATA_BUS_ARBITER_LOCK_EN
    input  m1_lock,
`endif
    input  m0_req, m0_addr, m0_wdata, m0_wr_w, m0_wr_h, m0_wr_b,
    output m0_stall, m0_rdata,
    input  m1_req, m1_addr, m1_wdata, m1_wr_w, m1_wr_h, m1_wr_b,
    output m1_gnt, m1_rdata, m1_rvalid,
    output s_addr, s_wdata, s_wr_w, s_wr_h, s_wr_b,
    input  s_rdata
  );

  // Environment view: the masters plus the shared slave's read data.
  modport master (
`ifdef DATA_BUS_ARBITER_LOCK_EN
    output m1_lock,
`endif
    output m0_req, m0_addr, m0_wdata, m0_wr_w, m0_wr_h, m0_wr_b,
    input  m0_stall, m0_rdata,
    output m1_req, m1_addr, m1_wdata, m1_wr_w, m1_wr_h, m1_wr_b,
    input  m1_gnt, m1_rdata, m1_rvalid,
    input  s_addr, s_wdata, s_wr_w, s_wr_h, s_wr_b,
    output s_rdata
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for the core data bus (M0 = core, M1 = DMA/debug) with burst
// limiting and read-data tagging. Optional M1 bus lock: DATA_BUS_ARBITER_LOCK_EN.
module data_bus_arbiter #(
  parameter int unsigned ADDR_BUS_WIDTH  = 16,
  parameter string       SYNCHRONOUS_RAM = "TRUE",
  parameter int unsigned MAX_BURST       = 4
) (
  input logic               clk,
  input logic               rst,
  data_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  localparam bit         SYNC_RAM    = (SYNCHRONOUS_RAM == "TRUE");
  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  owner_e     last_owner;
  owner_e     rd_owner;
  logic [3:0] burst_cnt;

  logic       gnt0;
  logic       gnt1;
  owner_e     gnt_owner;
  logic       m1_locked;
  logic       is_read;

  logic [ADDR_BUS_WIDTH-1:0] s_addr;
  logic [31:0]               s_wdata;
  logic [2:0]                s_wr;   // {w, h, b}

`ifdef DATA_BUS_ARBITER_LOCK_EN
  assign m1_locked = (last_owner == OWN_M1) && bus.m1_lock;
`else
  assign m1_locked = 1'b0;
`endif

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (bus.m0_req && !bus.m1_req) begin
      gnt0 = 1'b1;
    end else if (bus.m1_req && !bus.m0_req) begin
      gnt1 = 1'b1;
    end else if (bus.m0_req && bus.m1_req) begin
      if (m1_locked) begin
        gnt1 = 1'b1;
      end else if (last_owner == OWN_NONE) begin
        gnt0 = 1'b1;
      end else if (burst_cnt < BURST_LIMIT) begin
        gnt0 = (last_owner == OWN_M0);
        gnt1 = (last_owner == OWN_M1);
      end else begin
        gnt0 = (last_owner == OWN_M1);
        gnt1 = (last_owner == OWN_M0);
      end
    end
  end

  always_comb begin
    gnt_owner = OWN_NONE;
    s_addr    = '0;
    s_wdata   = '0;
    s_wr      = '0;
    if (gnt0) begin
      gnt_owner = OWN_M0;
      s_addr    = bus.m0_addr;
      s_wdata   = bus.m0_wdata;
      s_wr      = {bus.m0_wr_w, bus.m0_wr_h, bus.m0_wr_b};
    end else if (gnt1) begin
      gnt_owner = OWN_M1;
      s_addr    = bus.m1_addr;
      s_wdata   = bus.m1_wdata;
      s_wr      = {bus.m1_wr_w, bus.m1_wr_h, bus.m1_wr_b};
    end
  end

  assign is_read = (gnt0 || gnt1) && (s_wr == 3'b000);

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner <= OWN_NONE;
      burst_cnt  <= '0;
      rd_owner   <= OWN_NONE;
    end else begin
      if (gnt_owner == OWN_NONE) begin
        last_owner <= OWN_NONE;
        burst_cnt  <= '0;
      end else if (gnt_owner == last_owner) begin
        burst_cnt  <= (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;
      end else begin
        last_owner <= gnt_owner;
        burst_cnt  <= 4'd1;
      end
      // Tag the read so the returning data goes to its issuer even if ownership switches.
      rd_owner <= is_read ? gnt_owner : OWN_NONE;
    end
  end

  assign bus.m0_stall  = bus.m0_req & ~gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m1_rvalid = SYNC_RAM ? (rd_owner == OWN_M1) : (gnt1 & is_read);
  assign bus.m0_rdata  = bus.s_rdata;
  assign bus.m1_rdata  = bus.s_rdata;
  assign bus.s_addr    = s_addr;
  assign bus.s_wdata   = s_wdata;
  assign bus.s_wr_w    = s_wr[2];
  assign bus.s_wr_h    = s_wr[1];
  assign bus.s_wr_b    = s_wr[0];

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: a vector table for single-cycle behaviour plus
// hand-written sequences for bursts, read routing, reset and saturation.
module tb_data_bus_arbiter;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  data_bus_arbiter_if #(.ADDR_BUS_WIDTH(AW)) bus ();

  data_bus_arbiter #(
    .ADDR_BUS_WIDTH (AW),
    .SYNCHRONOUS_RAM("TRUE"),
    .MAX_BURST      (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic          m0_req;
    logic [AW-1:0] m0_addr;
    logic [31:0]   m0_wdata;
    logic [2:0]    m0_wr;      // {w, h, b}
    logic          m1_req;
    logic [AW-1:0] m1_addr;
    logic [31:0]   m1_wdata;
    logic [2:0]    m1_wr;
    logic [31:0]   s_rdata;
    logic [2:0]    exp_ctl;    // {m0_stall, m1_gnt, m1_rvalid}
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_wdata;
    logic [2:0]    exp_wr;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic [AW-1:0] a0, input logic [31:0] d0,
                       input logic [2:0] w0, input logic r1, input logic [AW-1:0] a1,
                       input logic [31:0] d1, input logic [2:0] w1, input logic [31:0] rd);
    bus.m0_req = r0; bus.m0_addr = a0; bus.m0_wdata = d0;
    {bus.m0_wr_w, bus.m0_wr_h, bus.m0_wr_b} = w0;
    bus.m1_req = r1; bus.m1_addr = a1; bus.m1_wdata = d1;
    {bus.m1_wr_w, bus.m1_wr_h, bus.m1_wr_b} = w1;
    bus.s_rdata = rd;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 3'b000, 1'b0, '0, '0, 3'b000, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  function automatic logic [63:0] bus_out();
    return {bus.m0_stall, bus.m1_gnt, bus.m1_rvalid, bus.s_addr, bus.s_wdata,
            bus.s_wr_w, bus.s_wr_h, bus.s_wr_b};
  endfunction

  logic exp1;

  initial begin
    vecs[0] = '{1'b0, 16'h0000, 32'h0,        3'b000, 1'b0, 16'h0000, 32'h0,        3'b000,
                32'h0,        3'b000, 16'h0000, 32'h0,        3'b000};
    vecs[1] = '{1'b0, 16'h0000, 32'h0,        3'b000, 1'b1, 16'h4010, 32'hDEADBEEF, 3'b100,
                32'h0,        3'b010, 16'h4010, 32'hDEADBEEF, 3'b100};
    vecs[2] = '{1'b0, 16'h0000, 32'h0,        3'b000, 1'b1, 16'h4000, 32'h0,        3'b000,
                32'h0,        3'b010, 16'h4000, 32'h0,        3'b000};
    vecs[3] = '{1'b1, 16'h0100, 32'h0,        3'b000, 1'b0, 16'h0000, 32'h0,        3'b000,
                32'h12345678, 3'b001, 16'h0100, 32'h0,        3'b000};
    vecs[4] = '{1'b0, 16'h0000, 32'h0,        3'b000, 1'b0, 16'h0000, 32'h0,        3'b000,
                32'hAAAA5555, 3'b000, 16'h0000, 32'h0,        3'b000};
    vecs[5] = '{1'b1, 16'h0200, 32'h11,       3'b001, 1'b1, 16'h0300, 32'h22,       3'b010,
                32'h0,        3'b000, 16'h0200, 32'h11,       3'b001};
    vecs[6] = '{1'b1, 16'h0204, 32'h0,        3'b000, 1'b1, 16'h0300, 32'h22,       3'b010,
                32'h0,        3'b000, 16'h0204, 32'h0,        3'b000};
    vecs[7] = '{1'b0, 16'h0000, 32'h0,        3'b000, 1'b1, 16'h0400, 32'h33,       3'b100,
                32'h0,        3'b010, 16'h0400, 32'h33,       3'b100};
    vecs[8] = '{1'b1, 16'h0208, 32'h0,        3'b000, 1'b1, 16'h0500, 32'h44,       3'b100,
                32'h0,        3'b110, 16'h0500, 32'h44,       3'b100};

`ifdef DATA_BUS_ARBITER_LOCK_EN
    bus.m1_lock = 1'b0;
`endif
    // Reset state: no requests while rst is low.
    rst = 1'b0;
    idle();
    #2;
    check("reset_idle", bus_out(), 64'h0);
    drive(1'b1, 16'h0010, 32'h0, 3'b000, 1'b1, 16'h4020, 32'h5, 3'b100, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_release_m0_wins", {bus.m0_stall, bus.m1_gnt, bus.s_addr}, {2'b00, 16'h0010});
    tick();

    // Single-cycle vector table, applied as one sequence from reset.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].m0_req, vecs[i].m0_addr, vecs[i].m0_wdata, vecs[i].m0_wr,
            vecs[i].m1_req, vecs[i].m1_addr, vecs[i].m1_wdata, vecs[i].m1_wr, vecs[i].s_rdata);
      @(negedge clk);
      check($sformatf("vec%0d_bus", i), bus_out(),
            {vecs[i].exp_ctl, vecs[i].exp_addr, vecs[i].exp_wdata, vecs[i].exp_wr});
      check($sformatf("vec%0d_rdata", i), {bus.m0_rdata, bus.m1_rdata},
            {vecs[i].s_rdata, vecs[i].s_rdata});
      tick();
    end

    // Continuous contention: M0 x4, M1 x4, M0 x4.
    do_reset();
    drive(1'b1, 16'h0001, 32'h0, 3'b000, 1'b1, 16'h4000, 32'h77, 3'b100, 32'h0);
    for (int i = 0; i < 12; i++) begin
      exp1 = (i >= 4) && (i < 8);
      @(negedge clk);
      check($sformatf("contend_%0d", i), {bus.m0_stall, bus.m1_gnt, bus.s_addr},
            {exp1, exp1, exp1 ? 16'h4000 : 16'h0001});
      tick();
    end

    // Read routing, including M0 read followed by M1 read.
    do_reset();
    drive(1'b0, '0, '0, 3'b000, 1'b1, 16'h4000, '0, 3'b000, 32'h0);
    @(negedge clk);
    check("rd_m1_issue", {bus.m1_gnt, bus.m1_rvalid}, 2'b10);
    tick();
    drive(1'b1, 16'h0008, '0, 3'b000, 1'b0, '0, '0, 3'b000, 32'h12345678);
    @(negedge clk);
    check("rd_m1_return", {bus.m1_rvalid, bus.m1_rdata}, {1'b1, 32'h12345678});
    tick();
    drive(1'b0, '0, '0, 3'b000, 1'b1, 16'h4004, '0, 3'b000, 32'hCAFEF00D);
    @(negedge clk);
    check("rd_m0_return_no_rvalid", {bus.m1_gnt, bus.m1_rvalid}, 2'b10);
    tick();
    drive(1'b0, '0, '0, 3'b000, 1'b0, '0, '0, 3'b000, 32'h0BADF00D);
    @(negedge clk);
    check("rd_m1_b2b_return", {bus.m1_rvalid, bus.m1_rdata}, {1'b1, 32'h0BADF00D});
    tick();
    @(negedge clk);
    check("rd_idle_no_rvalid", {31'h0, bus.m1_rvalid}, 32'h0);
    tick();

    // Reset in the cycle after an M1 read grant.
    do_reset();
    drive(1'b0, '0, '0, 3'b000, 1'b1, 16'h4000, '0, 3'b000, 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b1, 16'h0020, '0, 3'b000, 1'b1, 16'h4000, '0, 3'b000, 32'h99);
    #1;
    check("midreset_rvalid_dropped", {31'h0, bus.m1_rvalid}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp1 = (i == 4);
      @(negedge clk);
      check($sformatf("midreset_grant_%0d", i), {bus.m0_stall, bus.m1_gnt, bus.m1_rvalid},
            {exp1, exp1, 1'b0});
      tick();
    end

    // burst_cnt saturates at 15 instead of wrapping.
    do_reset();
    drive(1'b1, 16'h0030, 32'h1, 3'b100, 1'b0, '0, '0, 3'b000, 32'h0);
    repeat (17) tick();
    drive(1'b1, 16'h0030, 32'h1, 3'b100, 1'b1, 16'h4030, 32'h2, 3'b100, 32'h0);
    @(negedge clk);
    check("burst_saturate_switch", {bus.m0_stall, bus.m1_gnt, bus.s_addr}, {2'b11, 16'h4030});
    tick();

`ifdef DATA_BUS_ARBITER_LOCK_EN
    // Locked M1 keeps the bus past MAX_BURST; releasing the lock hands it to M0.
    do_reset();
    bus.m1_lock = 1'b1;
    drive(1'b0, '0, '0, 3'b000, 1'b1, 16'h4040, 32'h3, 3'b100, 32'h0);
    tick();
    drive(1'b1, 16'h0040, '0, 3'b000, 1'b1, 16'h4040, 32'h3, 3'b100, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("lock_hold_%0d", i), {bus.m0_stall, bus.m1_gnt}, 2'b11);
      tick();
    end
    bus.m1_lock = 1'b0;
    @(negedge clk);
    check("lock_release", {bus.m0_stall, bus.m1_gnt, bus.s_addr}, {2'b00, 16'h0040});
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
